// File: rtl/dpssram_stream_reader.sv
// dpssram_stream_reader
// ---------------------
// Read engine for the user port (port B) of the wbgen2 dual-port SRAM. A start
// command walks a contiguous, wrap-around address range. The engine absorbs the
// RAM's one-cycle read latency through a 4-entry FIFO and presents the words as
// a valid/ready stream, with a marker on the last beat.
//
// Ports
//   clk_i        single clock; the RAM user-port clock is tied to it
//   rst_i        synchronous reset, active-high
//   start_i      start command, sampled only in IDLE
//   base_i       first word address, captured with start_i
//   len_i        word count 0..2^g_addr_width, captured with start_i
//   busy_o       transfer in progress
//   done_o       one-cycle completion pulse
//   ram_addr_o   RAM port-B address
//   ram_rd_o     RAM port-B read strobe
//   ram_data_i   RAM port-B read data, valid the cycle after ram_rd_o
//   src_valid_o  stream word valid
//   src_data_o   stream word (FIFO head)
//   src_last_o   final word of the transfer
//   src_ready_i  downstream accept
module dpssram_stream_reader #(
  parameter int g_data_width = 32,
  parameter int g_addr_width = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [g_addr_width-1:0] base_i,
  input  logic [g_addr_width:0]   len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [g_addr_width-1:0] ram_addr_o,
  output logic                    ram_rd_o,
  input  logic [g_data_width-1:0] ram_data_i,
  output logic                    src_valid_o,
  output logic [g_data_width-1:0] src_data_o,
  output logic                    src_last_o,
  input  logic                    src_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [g_addr_width-1:0] ADDR_ONE = {{(g_addr_width-1){1'b0}}, 1'b1};
  localparam logic [g_addr_width:0]   LEN_ONE  = {{g_addr_width{1'b0}}, 1'b1};
  localparam logic [g_addr_width:0]   LEN_ZERO = {(g_addr_width+1){1'b0}};

  state_t                  r_state;
  logic                    r_rd;          // read strobe driven to the RAM
  logic                    r_rd_d;        // RAM data for the previous strobe is on ram_data_i
  logic [g_addr_width-1:0] r_addr;        // address of the most recently issued read
  logic [g_addr_width:0]   r_issue_left;  // reads still to be issued
  logic [g_addr_width:0]   r_beat_left;   // beats still to be delivered
  logic [g_data_width-1:0] r_fifo [4];
  logic [1:0]              r_wptr;
  logic [1:0]              r_rptr;
  logic [2:0]              r_count;

  state_t                  w_state_nxt;
  logic                    w_rd_nxt;
  logic [g_addr_width-1:0] w_addr_nxt;
  logic [g_addr_width:0]   w_issue_nxt;
  logic [g_addr_width:0]   w_beat_nxt;
  logic                    w_valid;
  logic                    w_push;
  logic                    w_pop;
  logic [3:0]              w_occupancy;
  logic                    w_can_issue;

  assign w_valid = (r_count != 3'd0);
  assign w_push  = r_rd_d;
  assign w_pop   = w_valid & src_ready_i;

  // Buffered words plus reads still in the RAM pipeline. Using the registered
  // FIFO count (not the pop) keeps src_ready_i out of the read-issue path.
  assign w_occupancy = {1'b0, r_count} + {3'b000, r_rd} + {3'b000, r_rd_d};
  assign w_can_issue = (r_issue_left != LEN_ZERO) && (w_occupancy < 4'd4);

  // Next-state and next datapath values for the transfer controller
  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_issue_nxt = r_issue_left;
    w_beat_nxt  = r_beat_left;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != LEN_ZERO) begin
            // First read goes out at base in the very next cycle.
            w_state_nxt = ST_RUN;
            w_rd_nxt    = 1'b1;
            w_addr_nxt  = base_i;
            w_issue_nxt = len_i - LEN_ONE;
            w_beat_nxt  = len_i;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_can_issue) begin
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = r_addr + ADDR_ONE;  // wraps naturally at 2^g_addr_width
          w_issue_nxt = r_issue_left - LEN_ONE;
        end else begin
          w_rd_nxt = 1'b0;
        end
        if (w_pop) begin
          w_beat_nxt = r_beat_left - LEN_ONE;
          if (r_beat_left == LEN_ONE) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_beat_nxt = r_beat_left;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Controller state, read strobe/address and transfer counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_rd         <= 1'b0;
      r_rd_d       <= 1'b0;
      r_addr       <= {g_addr_width{1'b0}};
      r_issue_left <= LEN_ZERO;
      r_beat_left  <= LEN_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_rd         <= w_rd_nxt;
      r_rd_d       <= r_rd;
      r_addr       <= w_addr_nxt;
      r_issue_left <= w_issue_nxt;
      r_beat_left  <= w_beat_nxt;
    end
  end

  // FIFO pointers and occupancy; reset flushes whatever was buffered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= ram_data_i;
    end
  end

  assign busy_o      = (r_state == ST_RUN);
  assign done_o      = (r_state == ST_DONE);
  assign ram_rd_o    = r_rd;
  assign ram_addr_o  = r_addr;
  assign src_valid_o = w_valid;
  assign src_data_o  = w_valid ? r_fifo[r_rptr] : {g_data_width{1'b0}};
  // Beats leave in order, so the head is the last word exactly when one remains.
  assign src_last_o  = w_valid && (r_beat_left == LEN_ONE);

endmodule

// File: tb/tb_dpssram_stream_reader.sv
// Directed testbench for dpssram_stream_reader with a behavioural RAM on port B.
module tb_dpssram_stream_reader;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  base_i;
  logic [10:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  ram_addr_o;
  logic        ram_rd_o;
  logic [31:0] ram_data_i;
  logic        src_valid_o;
  logic [31:0] src_data_o;
  logic        src_last_o;
  logic        src_ready_i;

  logic [31:0] mem [0:1023];
  int          n_cmp;
  int          n_fail;

  dpssram_stream_reader #(.g_data_width(32), .g_addr_width(10)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_i      (base_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_addr_o  (ram_addr_o),
    .ram_rd_o    (ram_rd_o),
    .ram_data_i  (ram_data_i),
    .src_valid_o (src_valid_o),
    .src_data_o  (src_data_o),
    .src_last_o  (src_last_o),
    .src_ready_i (src_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM: one-cycle registered read, write enable tied low
  always @(posedge clk) begin
    if (ram_rd_o) ram_data_i <= mem[ram_addr_o];
  end

  // Expected RAM content: 0xC0DE0000|addr, with A0..A3 at 0x10..0x13
  function automatic logic [31:0] exp_word(input logic [9:0] a);
    if (a >= 10'h010 && a <= 10'h013) return 32'h0000_00A0 + {22'd0, a} - 32'h0000_0010;
    else return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string t);
    chk({t, "_busy"},  {31'd0, busy_o},      32'd0);
    chk({t, "_done"},  {31'd0, done_o},      32'd0);
    chk({t, "_rd"},    {31'd0, ram_rd_o},    32'd0);
    chk({t, "_addr"},  {22'd0, ram_addr_o},  32'd0);
    chk({t, "_valid"}, {31'd0, src_valid_o}, 32'd0);
    chk({t, "_data"},  src_data_o,           32'd0);
    chk({t, "_last"},  {31'd0, src_last_o},  32'd0);
  endtask

  // Transfer with ready held high; start is re-pulsed at cycles g1/g2 (ignored)
  task automatic run_full(input string t, input logic [9:0] base, input int len,
                          input int g1, input int g2);
    logic [9:0] a;
    base_i = base; len_i = 11'(len); start_i = 1'b1; src_ready_i = 1'b1;
    for (int c = 1; c <= len + 4; c++) begin
      @(negedge clk);
      chk({t, "_busy"}, {31'd0, busy_o}, {31'd0, (c <= len + 2)});
      chk({t, "_done"}, {31'd0, done_o}, {31'd0, (c == len + 3)});
      chk({t, "_rd"},   {31'd0, ram_rd_o}, {31'd0, (c <= len)});
      if (c <= len) begin
        a = base + 10'(c - 1);
        chk({t, "_addr"}, {22'd0, ram_addr_o}, {22'd0, a});
      end
      chk({t, "_valid"}, {31'd0, src_valid_o}, {31'd0, (c >= 3 && c <= len + 2)});
      if (c >= 3 && c <= len + 2) begin
        a = base + 10'(c - 3);
        chk({t, "_data"}, src_data_o, exp_word(a));
        chk({t, "_last"}, {31'd0, src_last_o}, {31'd0, (c == len + 2)});
      end
      start_i = (c == g1 || c == g2);
      base_i  = 10'h080;
      len_i   = 11'd5;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int k;
    int issued;
    int done_cnt;
    logic rdy;
    logic [9:0] a;

    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[16] = 32'h0000_00A0; mem[17] = 32'h0000_00A1;
    mem[18] = 32'h0000_00A2; mem[19] = 32'h0000_00A3;
    ram_data_i = 32'd0;
    rst_i = 1'b1; start_i = 1'b0; base_i = 10'd0; len_i = 11'd0; src_ready_i = 1'b1;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Basic and wrap-around transfers
    run_full("basic", 10'h010, 4, -1, -1);
    run_full("wrap",  10'h3FE, 4, -1, -1);

    // Zero length: done in cycle 1, nothing issued or streamed
    base_i = 10'h005; len_i = 11'd0; start_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      chk("zero_done",  {31'd0, done_o},      {31'd0, (c == 1)});
      chk("zero_busy",  {31'd0, busy_o},      32'd0);
      chk("zero_rd",    {31'd0, ram_rd_o},    32'd0);
      chk("zero_valid", {31'd0, src_valid_o}, 32'd0);
    end

    // Backpressure: len=16, ready low in cycles 4..13, random afterwards
    base_i = 10'h020; len_i = 11'd16; start_i = 1'b1; src_ready_i = 1'b1;
    k = 0; issued = 0; done_cnt = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ram_rd_o) begin
        a = 10'h020 + 10'(issued);
        chk("bp_addr", {22'd0, ram_addr_o}, {22'd0, a});
        issued++;
      end
      chk("bp_buffered", {31'd0, ((issued - k) <= 4)}, 32'd1);
      if (src_valid_o) begin
        a = 10'h020 + 10'(k);
        chk("bp_data", src_data_o, exp_word(a));
        chk("bp_last", {31'd0, src_last_o}, {31'd0, (k == 15)});
      end
      if (done_o) done_cnt++;
      if (c < 4) rdy = 1'b1;
      else if (c <= 13) rdy = 1'b0;
      else rdy = 1'($urandom_range(0, 1));
      src_ready_i = rdy;
      if (src_valid_o && rdy) k++;
    end
    src_ready_i = 1'b1;
    chk("bp_beats",  k,        32'd16);
    chk("bp_issued", issued,   32'd16);
    chk("bp_dones",  done_cnt, 32'd1);

    // Start pulses while busy and while in DONE are ignored
    run_full("ignore", 10'h040, 8, 3, 11);

    // Reset in cycle 5 of a len=8 transfer
    base_i = 10'h050; len_i = 11'd8; start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk_idle_outputs("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_done",  {31'd0, done_o},      32'd0);
      chk("midrst_valid", {31'd0, src_valid_o}, 32'd0);
      chk("midrst_rd",    {31'd0, ram_rd_o},    32'd0);
    end
    run_full("after_rst", 10'h060, 2, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dpssram_stream_reader.md
# dpssram_stream_reader

User-side read engine for the wbgen2 dual-port SRAM. On a start command it walks a contiguous, wrap-around address range on the RAM's user port (port B), absorbs the RAM's one-cycle read latency, and presents the words as a valid/ready stream with a last-beat marker. It is the consumer end of buffers that software fills through the Wishbone side (port A).

## Interface
Parameters:
- g_data_width, 32, RAM word width; must equal the RAM instance width.
- g_addr_width, 10, RAM address width; must equal the RAM instance address width.

Ports:
- clk_i  in  1  single clock; the RAM user-port clock is tied to it.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start command; sampled only in IDLE.
- base_i  in  g_addr_width  first word address, sampled with start_i.
- len_i  in  g_addr_width+1  word count, 0..2^g_addr_width, sampled with start_i.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- ram_addr_o  out  g_addr_width  to RAM port-B address.
- ram_rd_o  out  1  to RAM port-B read strobe.
- ram_data_i  in  g_data_width  RAM port-B read data; valid the cycle after ram_rd_o.
- src_valid_o  out  1  stream word valid.
- src_data_o  out  g_data_width  stream word.
- src_last_o  out  1  marks the final word of the transfer.
- src_ready_i  in  1  downstream accept.

The block never drives RAM port-B writes; the write enable is tied low at instantiation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 captures base_i and len_i.
  - len_i≠0: go to RUN. busy_o=1 from the next cycle.
  - len_i=0: go to DONE. No reads and no beats are issued.
- RUN, read issue:
  - ram_rd_o and ram_addr_o are registered.
  - ram_rd_o is high in cycle t+1 iff words-left-to-issue>0 and fifo_count(t)+outstanding(t)<4.
  - outstanding(t) = ram_rd_o(t) + (read whose data is on ram_data_i at t).
  - ram_addr_o increments per issued read, modulo 2^g_addr_width (wraps 2^aw−1→0).
- Capture: ram_data_i is written into a 4-entry FIFO one cycle after its ram_rd_o. With the issue rule above the FIFO never overflows.
- Stream output:
  - src_valid_o=1 whenever the FIFO is non-empty; src_data_o is the FIFO head.
  - A beat completes when src_valid_o & src_ready_i.
  - While valid and not ready, src_data_o and src_last_o hold stable.
  - src_last_o=1 only with the len-th word.
- RUN→DONE on the cycle the last beat completes.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- start_i while busy_o=1 or in DONE is ignored.
- rst_i mid-transfer: on the next edge, state→IDLE and the FIFO is flushed. Any in-flight RAM data is discarded, and no done_o is generated.

## Timing
- Reset values: busy_o=0, done_o=0, ram_rd_o=0, ram_addr_o=0, src_valid_o=0, src_data_o=0, src_last_o=0.
- Start sampled in cycle 0 → ram_rd_o=1 with ram_addr_o=base in cycle 1 → ram_data_i valid in cycle 2 → src_valid_o=1 in cycle 3.
- First-word latency is 3 cycles.
- With src_ready_i held high: one beat per cycle, no bubbles.
  - A len=N transfer has its last beat in cycle N+2 and done_o in cycle N+3.
- No combinational path from src_ready_i to ram_rd_o or ram_addr_o.
- After src_ready_i drops, at most 4 words are buffered. ram_rd_o deasserts no later than 2 cycles after the FIFO reaches 2 entries with outstanding=2.

## Test plan
- Basic: RAM[0x10..0x13]=A0..A3, base=0x10, len=4, ready=1 → src_data_o=A0,A1,A2,A3 on cycles 3..6; src_last_o only on A3; done_o pulse in cycle 7; busy_o high in cycles 1..6.
- Wrap: base=0x3FE, len=4 → ram_addr_o sequence 0x3FE,0x3FF,0x000,0x001; stream data matches in order.
- Backpressure: len=16; src_ready_i low for cycles 4..13, random afterwards.
  - All 16 words delivered in order with none lost or duplicated.
  - Data stable while stalled; never more than 4 buffered words.
- Zero length: start with len_i=0 → no ram_rd_o, no src_valid_o, done_o in cycle 1.
- Ignored start: start_i pulsed with a different base during the busy period of a len=8 transfer → the original 8 words only; exactly one done_o.
- Reset mid-transfer: rst_i in cycle 5 of a len=8 transfer → all outputs at reset values next cycle; no done_o. A following start with len=2 streams correctly.
